hpdcache_rsp_router: RTL

In-order response router that forms the return path of a round-robin arbitrated request channel. It records the index of every granted requester in a tracking FIFO when its request is accepted downstream. It then steers each returning response, with valid/ready flow control, to the requester at the FIFO head. It sits between the single shared response port and N requester response ports, paired with the arbiter that serialises the request side.

---
 rtl/hpdcache_rsp_router.sv | 119 +++++++++++
 1 files changed

// File: rtl/hpdcache_rsp_router.sv
// rtl/hpdcache_rsp_router.sv - in-order response router driven by a tracking FIFO of granted requester indices
module hpdcache_rsp_router #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N-1:0]                 req_gnt_i,
  input  logic                         req_fire_i,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         err_o,
  input  logic                         rsp_valid_i,
  output logic                         rsp_ready_o,
  input  logic [W-1:0]                 rsp_data_i,
  output logic [N-1:0]                 rsp_valid_o,
  input  logic [N-1:0]                 rsp_ready_i,
  output logic [N*W-1:0]               rsp_data_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (N < 1) begin : g_bad_n
    $error("hpdcache_rsp_router: N must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("hpdcache_rsp_router: DEPTH must be >= 1");
  end

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] head;
  logic          gnt_onehot;
  logic          empty, full;
  logic          lane_rdy;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign gnt_onehot = (req_gnt_i != '0) && ((req_gnt_i & (req_gnt_i - N'(1))) == '0);

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req_gnt_i[i]) gnt_idx = IW'(i);
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rptr_q];

  // Only the head lane sees the response; the empty check keeps a stale head from leaking out.
  always_comb begin
    rsp_valid_o = '0;
    lane_rdy    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (head == IW'(i)) begin
        rsp_valid_o[i] = rsp_valid_i & ~empty;
        lane_rdy       = rsp_ready_i[i];
      end
    end
  end

  assign rsp_ready_o = ~empty & lane_rdy;
  assign rsp_data_o  = {N{rsp_data_i}};

  assign pop  = rsp_valid_i & rsp_ready_o;
  assign push = req_fire_i & gnt_onehot & (~full | pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q | (req_fire_i & ~gnt_onehot) | (req_fire_i & gnt_onehot & full & ~pop);
    if (push) begin
      mem_d[wptr_q] = gnt_idx;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign full_o        = full;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule
